// File: rtl/l2_bank_init_ctrl_if.sv
// TCDM port plus SRAM-cut port of one L2 bank, bundled for the bank front-end.
// The slave modport is the bank controller; the master modport is its environment.
interface l2_bank_init_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                  req_i;
  logic                  gnt_o;
  logic [ADDR_WIDTH-1:0] add_i;
  logic                  wen_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic [BE_WIDTH-1:0]   be_i;
  logic [DATA_WIDTH-1:0] rdata_o;

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [BE_WIDTH-1:0]   mem_be_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  req_i, add_i, wen_i, wdata_i, be_i, mem_rdata_i,
    output gnt_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );

  modport master (
    output req_i, add_i, wen_i, wdata_i, be_i, mem_rdata_i,
    input  gnt_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );
endinterface

// File: rtl/l2_bank_init_ctrl.sv
// Per-bank L2 front-end: fills the SRAM cut with INIT_VALUE after reset or on request,
// then passes TCDM traffic straight through with a fixed 1-cycle read latency.
module l2_bank_init_ctrl #(
  parameter int unsigned           BANK_SIZE     = 32768,
  parameter int unsigned           ADDR_WIDTH    = $clog2(BANK_SIZE),
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
  parameter bit                    INIT_ON_RESET = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic init_req_i,
  output logic init_done_o,
  output logic busy_o,
  l2_bank_init_ctrl_if.slave bus
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(BANK_SIZE - 1);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    ARM  = 2'd2
  } state_t;

  localparam state_t RESET_STATE = INIT_ON_RESET ? INIT : RUN;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_done_q, busy_q;

  // Status flags are registered from the next state so they line up with the state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RESET_STATE;
      cnt_q       <= '0;
      init_done_q <= !INIT_ON_RESET;
      busy_q      <= INIT_ON_RESET;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= (state_d == RUN);
      busy_q      <= (state_d != RUN);
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bus.gnt_o       = 1'b0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = cnt_q;
    bus.mem_wdata_o = INIT_VALUE;
    bus.mem_be_o    = {BE_WIDTH{1'b1}};

    unique case (state_q)
      INIT: begin
        bus.mem_req_o = 1'b1;
        bus.mem_we_o  = 1'b1;
        if (cnt_q == LAST_WORD) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      RUN: begin
        bus.gnt_o       = bus.req_i;
        bus.mem_req_o   = bus.req_i;
        bus.mem_we_o    = ~bus.wen_i;
        bus.mem_addr_o  = bus.add_i;
        bus.mem_wdata_o = bus.wdata_i;
        bus.mem_be_o    = bus.be_i;
        if (init_req_i) begin
          state_d = ARM;
          cnt_d   = '0;
        end
      end
      // One idle cycle lets the response to the last RUN read drain before the fill starts.
      ARM: begin
        state_d = INIT;
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.rdata_o = bus.mem_rdata_i;
  assign init_done_o = init_done_q;
  assign busy_o      = busy_q;

endmodule
